serial_comple_ctrl: RTL
=======================

Name: serial_comple_ctrl

Overview:
- Bit-serial two's-complement sequencer: accepts a WIDTH-bit operand on a start pulse and produces its two's complement LSB-first, one bit per clock.
- Uses the copy-until-first-1-then-invert rule.
- Used as a low-area alternative to the parallel complement unit; it sequences operand load, bit processing and result hand-back for the CA datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse, sampled only in IDLE
- inp  input  WIDTH  operand, captured on the edge start is accepted
- out  output  WIDTH  registered result, holds last completed value
- busy  output  1  high while an operation is in flight (COPY/INVERT)
- done  output  1  one-cycle pulse, out valid for the new result

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, out=0, busy=0, done=0, shift register=0, result register=0, bit counter=0.
- States: IDLE, COPY, INVERT, DONE.
- IDLE, start=1 at edge N:
  - load inp into shift register; clear counter and result; go to COPY; busy=1 after edge N.
- COPY, each edge: result bit[cnt] = sreg[0].
  - If sreg[0]=1, next state is INVERT; otherwise stay in COPY.
  - Shift sreg right; cnt++.
- INVERT, each edge: result bit[cnt] = ~sreg[0]; shift; cnt++.
- Completion: on the edge processing bit WIDTH-1 (edge N+WIDTH), load out from the completed result, go to DONE, busy=0.
- DONE: done=1 for exactly one cycle (edge N+WIDTH to N+WIDTH+1); next state is IDLE unconditionally.
- Latency: start accepted at edge N -> out valid and done=1 after edge N+WIDTH. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy or in DONE: ignored, no queuing; inp changes during operation have no effect.
- out changes only on the completion edge (or reset); it is stable at all other times.
- Arithmetic: out = (~inp + 1) mod 2^WIDTH.
  - inp=0 -> out=0; stays in COPY for the whole operation.
  - inp=2^(WIDTH-1) (most negative) -> out equals inp.
- Reset mid-operation: aborts immediately at the next edge. No done pulse; out returns to 0.
- start and rst high together: rst wins.

Optional Feature:
- Macro: COMPLE_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), registered with out on the completion edge. ovf=1 iff inp was 2^(WIDTH-1), i.e. the only nonzero operand whose complement equals itself; held until the next completion or reset.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Decomposition:
- Package comple_pkg:
  - state encoding localparams: IDLE=2'd0, COPY=2'd1, INVERT=2'd2, DONE=2'd3;
  - default WIDTH constant;
  - counter-width helper constant, clog2(WIDTH).
- One natural sub-module, comple_bit_cell: combinational per-bit rule. Inputs bit_in, inverting; outputs bit_out and next_inverting = inverting | bit_in.
- The top level holds the FSM, shift register, counter and output registers.

Test Plan:
- Reset then idle: rst high 2 cycles -> out=0, busy=0, done=0; start low for 10 cycles -> no change.
- Basic op, WIDTH=4: inp=4'b0110, start at edge N -> busy=1 for edges N+1..N+4, then out=4'b1010 and done=1 for exactly one cycle after edge N+4.
- Exhaustive: sweep inp 0..15, one op each, compare with (~inp+1)&4'hF. Zero case: inp=0 -> out=0. Most-negative case: inp=4'b1000 -> out=4'b1000, and ovf=1 when COMPLE_OVF_EN is defined.
- Ignored start: start held high throughout an op with inp=4'b0011, inp changed to 4'b1111 at N+2 -> exactly one done, out=4'b1101. A second op begins only after returning to IDLE.
- Reset mid-op: after a prior result out=4'b1010, start inp=4'b0001, assert rst at N+2 -> no done, out=0, busy=0. A new start afterwards completes normally: 4'b0001 -> 4'b1111.

Source files
------------

// File: rtl/serial_comple_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// comple_pkg
//   Shared definitions for the bit-serial two's-complement sequencer:
//     - state_t       : FSM state encoding (IDLE/COPY/INVERT/DONE)
//     - DEFAULT_WIDTH : default operand/result width
//     - DEFAULT_CNT_W : bit-counter width for the default operand width
//     - cnt_width()   : bit-counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package comple_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 4;

    // FSM state encoding. COPY passes bits through until the first 1 has been
    // consumed; INVERT complements every remaining bit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        INVERT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of a counter indexing bits 0..w-1. Clamped to 1 so the counter
    // never collapses to a zero-width vector.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage : comple_pkg

// File: rtl/serial_comple_ctrl_bit_cell.sv
// -----------------------------------------------------------------------------
// comple_bit_cell
//   Combinational per-bit rule of the copy-until-first-1-then-invert
//   two's-complement algorithm.
//
//   Ports:
//     bit_in         : current operand bit (LSB-first)
//     inverting      : 1 once a 1 has already been seen in lower bits
//     bit_out        : result bit (bit_in, or ~bit_in when inverting)
//     next_inverting : inverting state for the next bit position
// -----------------------------------------------------------------------------
module comple_bit_cell (
    input  logic bit_in,
    input  logic inverting,
    output logic bit_out,
    output logic next_inverting
);

    // Bits up to and including the first 1 are copied; all later bits are
    // inverted. XOR implements "copy or invert" in one gate.
    assign bit_out        = bit_in ^ inverting;
    assign next_inverting = inverting | bit_in;

endmodule : comple_bit_cell

// File: rtl/serial_comple_ctrl.sv
// -----------------------------------------------------------------------------
// serial_comple_ctrl
//   Bit-serial two's-complement sequencer. A WIDTH-bit operand is captured on
//   an accepted start pulse and its two's complement is produced LSB-first,
//   one bit per clock, using the copy-until-first-1-then-invert rule. The
//   finished result is handed back on `out` with a one-cycle `done` pulse.
//
//   Timing: start accepted at edge N -> busy high after edges N..N+WIDTH-1,
//   out/done updated at edge N+WIDTH, back in IDLE after edge N+WIDTH+1.
//
//   Parameters:
//     WIDTH : operand/result width in bits (>= 2)
//
//   Ports:
//     clk   : system clock, all state on rising edge
//     rst   : synchronous reset, active-high (wins over start)
//     start : request pulse, only honoured in IDLE
//     inp   : operand, captured on the edge start is accepted
//     out   : registered result, holds the last completed value
//     busy  : high while an operation is in flight (COPY/INVERT)
//     done  : one-cycle pulse when out carries a new result
//     ovf   : (only with COMPLE_OVF_EN defined) set with out when the operand
//             was the most negative value, whose complement is itself
//
//   Build option:
//     COMPLE_OVF_EN : when defined, adds the ovf output and its register.
// -----------------------------------------------------------------------------
module serial_comple_ctrl
    import comple_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
`ifdef COMPLE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_reg;
    logic [WIDTH-1:0] sreg_reg;     // operand, shifted right one bit per cycle
    logic [CNT_W-1:0] cnt_reg;      // index of the bit being processed
    logic [WIDTH-1:0] result_reg;   // partially assembled complement
    logic [WIDTH-1:0] out_reg;
    logic             busy_reg;
    logic             done_reg;
`ifdef COMPLE_OVF_EN
    logic             ovf_reg;
    logic             ovf_next;
`endif

    // -------------------------------------------------------------------------
    // Per-bit rule: a single cell reused every cycle on the current LSB.
    // The "inverting" flag is simply whether the FSM has reached INVERT.
    // -------------------------------------------------------------------------
    logic bit_out;
    logic next_inverting;
    logic inverting;

    assign inverting = (state_reg == INVERT);

    comple_bit_cell u_bit_cell (
        .bit_in         (sreg_reg[0]),
        .inverting      (inverting),
        .bit_out        (bit_out),
        .next_inverting (next_inverting)
    );

    // -------------------------------------------------------------------------
    // Result with the current bit merged in. Built as a per-bit decode so the
    // completion edge can load `out` directly from it without waiting a cycle
    // for result_reg to catch up.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] result_next;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_result
        assign result_next[gi] = (cnt_reg == CNT_W'(gi)) ? bit_out
                                                         : result_reg[gi];
    end

    // -------------------------------------------------------------------------
    // Overflow: the only nonzero operand whose complement is itself is
    // 100...0. That is exactly the case where the FSM is still in COPY (no
    // lower 1 seen) when the final bit arrives and that bit is 1.
    // -------------------------------------------------------------------------
`ifdef COMPLE_OVF_EN
    assign ovf_next = (state_reg == COPY) && sreg_reg[0];
`endif

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            sreg_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            out_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef COMPLE_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        sreg_reg   <= inp;
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= COPY;
                    end
                end

                COPY, INVERT: begin
                    result_reg <= result_next;
                    sreg_reg   <= {1'b0, sreg_reg[WIDTH-1:1]};
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        // Last bit: hand the finished result back.
                        out_reg   <= result_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
`ifdef COMPLE_OVF_EN
                        ovf_reg   <= ovf_next;
`endif
                    end else begin
                        // Once a 1 has been consumed, stay in INVERT.
                        state_reg <= next_inverting ? INVERT : COPY;
                    end
                end

                DONE: begin
                    // Start is ignored here; requests are not queued.
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = out_reg;
    assign busy = busy_reg;
    assign done = done_reg;
`ifdef COMPLE_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule : serial_comple_ctrl
